// File: rtl/ff_gain_stage_pkg.sv
// ff_gain_stage_pkg
//   Shared defaults and types for the feed-forward gain stage and any other
//   gain path built from the same pieces.
//   - *_W_DEF / GAIN_SHIFT_DEF : default parameter values
//   - ff_state_t               : pulse-statistics FSM state
package ff_gain_stage_pkg;

  localparam int DIN_W_DEF      = 13;
  localparam int GAIN_W_DEF     = 7;
  localparam int DOUT_W_DEF     = 16;
  localparam int GAIN_SHIFT_DEF = 3;
  localparam int CNT_W_DEF      = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_PUBLISH = 2'd2
  } ff_state_t;

endpackage

// File: rtl/ff_gain_stage_sat_scale.sv
// sat_scale
//   Combinational arithmetic right shift followed by saturation to a narrower
//   signed word.
//   Ports:
//     din  : signed product, IN_W bits
//     dout : signed result clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//     sat  : high when clamping took place
//   IN_W must be larger than OUT_W.
module sat_scale #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 16,
  parameter int SHIFT = 3
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  // Bitwise inverse of the positive limit is exactly the negative limit.
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  logic signed [IN_W-1:0] shifted;

  assign shifted = din >>> SHIFT;

  always_comb begin
    sat  = 1'b0;
    dout = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      sat  = 1'b1;
      dout = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (shifted < MIN_V) begin
      sat  = 1'b1;
      dout = {1'b1, {(OUT_W - 1){1'b0}}};
    end
  end

endmodule

// File: rtl/ff_gain_stage.sv
// ff_gain_stage
//   Feed-forward gain stage ahead of the amplifier-drive output. During the
//   store-strobe window it computes (din - offset) * gain, shifts and
//   saturates to the drive word, and forwards a strobe aligned with the
//   result. Gain changes only take effect between pulses. Per-pulse
//   saturation statistics are reported to the host.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     store_strb   : processing window from upstream
//     din, offset  : signed sample and offset subtracted from it
//     gain_new     : host gain value, captured on gain_load
//     dout         : scaled, saturated drive word (2-cycle latency)
//     strb_out     : store_strb delayed 2 cycles, aligned with dout
//     gain_active  : gain currently multiplying the samples
//     sat_flag     : a sample of the current/last pulse saturated
//     sat_count    : saturated-sample count of the last completed pulse
//     fsm_state    : pulse-statistics FSM state, for observation
//   Handshake: there is no back-pressure; store_strb/strb_out act as valid
//   qualifiers and data is meaningful only on cycles where they are high.
module ff_gain_stage
  import ff_gain_stage_pkg::*;
#(
  parameter int DIN_W      = DIN_W_DEF,
  parameter int GAIN_W     = GAIN_W_DEF,
  parameter int DOUT_W     = DOUT_W_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     store_strb,
  input  logic signed [DIN_W-1:0]  din,
  input  logic signed [DIN_W-1:0]  offset,
  input  logic signed [GAIN_W-1:0] gain_new,
  input  logic                     gain_load,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     strb_out,
  output logic signed [GAIN_W-1:0] gain_active,
  output logic                     sat_flag,
  output logic [CNT_W-1:0]         sat_count,
  output ff_state_t                fsm_state
);

  localparam int DIFF_W = DIN_W + 1;
  localparam int PROD_W = DIFF_W + GAIN_W;

  // ---------------- stage 1: offset subtraction ----------------
  logic signed [DIFF_W-1:0] diff_q;
  logic                     strb_d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q  <= '0;
      strb_d1 <= 1'b0;
    end else begin
      strb_d1 <= store_strb;
      if (store_strb) begin
        diff_q <= {din[DIN_W-1], din} - {offset[DIN_W-1], offset};
      end else begin
        diff_q <= '0;
      end
    end
  end

  // ---------------- stage 2: gain, shift, saturate ----------------
  logic signed [PROD_W-1:0] prod;
  logic signed [DOUT_W-1:0] scaled;
  logic                     scaled_sat;
  logic                     sat_q;

  assign prod = PROD_W'(diff_q) * PROD_W'(gain_active);

  sat_scale #(
    .IN_W  (PROD_W),
    .OUT_W (DOUT_W),
    .SHIFT (GAIN_SHIFT)
  ) u_sat_scale (
    .din  (prod),
    .dout (scaled),
    .sat  (scaled_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      sat_q    <= 1'b0;
      strb_out <= 1'b0;
    end else begin
      dout     <= scaled;
      sat_q    <= scaled_sat;
      strb_out <= strb_d1;
    end
  end

  // ---------------- gain latch ----------------
  // The middle pipeline stage is also required to be empty so that a
  // one-cycle pulse still in flight is scaled by the gain it started with.
  logic signed [GAIN_W-1:0] gain_pending;
  logic                     pend;
  logic                     gain_apply;

  assign gain_apply = pend && !store_strb && !strb_d1 && !strb_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain_active  <= '0;
      gain_pending <= '0;
      pend         <= 1'b0;
    end else begin
      if (gain_apply) begin
        gain_active <= gain_pending;
      end
      // A load on the apply cycle keeps pend set, so the new value is
      // applied on the following cycle.
      if (gain_load) begin
        gain_pending <= gain_new;
        pend         <= 1'b1;
      end else if (gain_apply) begin
        pend <= 1'b0;
      end
    end
  end

  // ---------------- pulse statistics FSM ----------------
  ff_state_t        state_q;
  ff_state_t        state_d;
  logic             pulse_start;
  logic             pulse_count;
  logic             pulse_publish;
  logic [CNT_W-1:0] sat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (strb_out) state_d = ST_ACTIVE;
      ST_ACTIVE:  if (!strb_out) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = strb_out ? ST_ACTIVE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The first sample of a pulse is seen in the same cycle the pulse is
  // detected, so a start also counts that sample.
  always_comb begin
    pulse_start   = 1'b0;
    pulse_count   = 1'b0;
    pulse_publish = 1'b0;
    case (state_q)
      ST_IDLE:    pulse_start = strb_out;
      ST_ACTIVE:  pulse_count = strb_out && sat_q;
      ST_PUBLISH: begin
        pulse_publish = 1'b1;
        pulse_start   = strb_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag  <= 1'b0;
      sat_cnt_q <= '0;
      sat_count <= '0;
    end else begin
      if (pulse_start) begin
        sat_flag  <= sat_q;
        sat_cnt_q <= {{(CNT_W - 1){1'b0}}, sat_q};
      end else if (pulse_count) begin
        sat_flag <= 1'b1;
        if (sat_cnt_q != '1) begin
          sat_cnt_q <= sat_cnt_q + 1'b1;
        end
      end
      if (pulse_publish) begin
        sat_count <= sat_cnt_q;
      end
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_ff_gain_stage.sv
// tb_ff_gain_stage
//   Directed bench for ff_gain_stage. A behavioural model predicts every
//   output each cycle; literal expectations pin the model at key points.
module tb_ff_gain_stage;
  import ff_gain_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               store_strb = 1'b0;
  logic signed [12:0] din        = '0;
  logic signed [12:0] offset     = '0;
  logic signed [6:0]  gain_new   = '0;
  logic               gain_load  = 1'b0;
  logic signed [15:0] dout;
  logic               strb_out;
  logic signed [6:0]  gain_active;
  logic               sat_flag;
  logic [9:0]         sat_count;
  ff_state_t          fsm_state;

  ff_gain_stage dut (
    .clk         (clk),
    .rst         (rst),
    .store_strb  (store_strb),
    .din         (din),
    .offset      (offset),
    .gain_new    (gain_new),
    .gain_load   (gain_load),
    .dout        (dout),
    .strb_out    (strb_out),
    .gain_active (gain_active),
    .sat_flag    (sat_flag),
    .sat_count   (sat_count),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Samples accepted in a cycle appear two cycles later; gain is the value
  // active while the sample is multiplied.
  int   s_diff;   // sample taken in the previous cycle
  logic s_v;
  int   m_dout, m_gain, m_pgain, m_cnt, m_sc, pub_v;
  logic m_strb, m_sat, m_pend, m_flag, m_strb_prev, pub_t;

  function automatic int scale(input int diff, input int g, output logic sat);
    int s;
    s   = (diff * g) >>> 3;
    sat = 1'b0;
    if (s > 32767)  begin s = 32767;  sat = 1'b1; end
    if (s < -32768) begin s = -32768; sat = 1'b1; end
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic apply, nsat;
    int   nd;
    if (rst) begin
      s_diff = 0; s_v = 0; m_dout = 0; m_gain = 0; m_pgain = 0; m_cnt = 0;
      m_sc = 0; pub_v = 0; m_strb = 0; m_sat = 0; m_pend = 0; m_flag = 0;
      m_strb_prev = 0; pub_t = 0;
    end else begin
      // statistics over the output stream seen this cycle
      if (pub_t) begin m_sc = pub_v; pub_t = 0; end
      if (m_strb && !m_strb_prev) begin
        m_cnt  = m_sat ? 1 : 0;
        m_flag = m_sat;
      end else if (m_strb && m_sat) begin
        m_cnt  = (m_cnt < 1023) ? m_cnt + 1 : 1023;
        m_flag = 1'b1;
      end
      if (!m_strb && m_strb_prev) begin pub_v = m_cnt; pub_t = 1; end
      m_strb_prev = m_strb;
      // gain changes only when no sample is anywhere in the pipe
      apply = m_pend && !store_strb && !s_v && !m_strb;
      nd     = scale(s_diff, m_gain, nsat);
      m_dout = nd;
      m_sat  = nsat;
      m_strb = s_v;
      s_v    = store_strb;
      s_diff = store_strb ? int'(din) - int'(offset) : 0;
      if (apply) m_gain = m_pgain;
      if (gain_load) begin m_pgain = int'(gain_new); m_pend = 1; end
      else if (apply) m_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("dout",        int'(dout),        m_dout);
      check("strb_out",    int'(strb_out),    int'(m_strb));
      check("gain_active", int'(gain_active), m_gain);
      check("sat_flag",    int'(sat_flag),    int'(m_flag));
      check("sat_count",   int'(sat_count),   m_sc);
    end
  end

  // strobe width monitor
  int run_w = 0;
  int last_w = 0;
  always @(negedge clk) begin
    if (rst) run_w <= 0;
    else if (strb_out) run_w <= run_w + 1;
    else if (run_w != 0) begin last_w <= run_w; run_w <= 0; end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk) #1;
      store_strb = 1'b0;
      gain_load  = 1'b0;
    end
  endtask

  // Loads a gain in an idle period; returns one cycle after the load cycle.
  task automatic load_gain(input int g);
    @(posedge clk) #1;
    gain_new  = 7'(g);
    gain_load = 1'b1;
    @(posedge clk) #1;
    gain_load = 1'b0;
  endtask

  // Pulse of len samples: first nsat use d_sat, rest d_ok. Optional dout probe
  // at index probe_i and gain load at index load_i (-1 disables). Returns in
  // the first cycle after the strobe fell.
  task automatic pulse(input int len, input int nsat, input int d_sat, input int d_ok,
                       input int probe_i, input int probe_exp, input int load_i,
                       input int load_g, input string name);
    for (int i = 0; i < len; i++) begin
      @(posedge clk) #1;
      store_strb = 1'b1;
      din        = 13'((i < nsat) ? d_sat : d_ok);
      gain_load  = (i == load_i);
      gain_new   = 7'(load_g);
      if (i == probe_i) check(name, int'(dout), probe_exp);
    end
    @(posedge clk) #1;
    store_strb = 1'b0;
    gain_load  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_dout",  int'(dout), 0);
    check("rst_gain",  int'(gain_active), 0);
    check("rst_state", int'(fsm_state), int'(ST_IDLE));

    // gain load while idle: visible two cycles after the load cycle
    load_gain(16);
    check("gain_idle_n1", int'(gain_active), 0);
    @(posedge clk) #1;
    check("gain_idle_n2", int'(gain_active), 16);

    // basic scaling: (1000-200)*16 >>> 3 = 1600
    offset = 13'sd200;
    idle(2);
    pulse(40, 0, 0, 1000, 20, 1600, -1, 0, "t1_dout");
    idle(5);
    check("t1_width", last_w, 40);
    check("t1_satcnt", int'(sat_count), 0);

    // positive saturation: 10 of 20 samples clamp to 32767
    // (4095+4096)*63>>>3 = 64504 clamps; (0+4096)*63>>>3 = 32256
    offset = -13'sd4096;
    load_gain(63);
    idle(2);
    pulse(20, 10, 4095, 0, 5, 32767, -1, 0, "t2_dout_sat");
    idle(5);
    check("t2_satcnt", int'(sat_count), 10);
    check("t2_flag", int'(sat_flag), 1);

    // negative saturation
    offset = 13'sd4095;
    pulse(6, 6, -4096, 0, 4, -32768, -1, 0, "t3_dout_neg");
    idle(5);
    check("t3_satcnt", int'(sat_count), 6);

    // gain -1, din 8: -8 >>> 3 = -1, no saturation
    offset = 13'sd0;
    load_gain(-1);
    idle(2);
    pulse(6, 0, 0, 8, 4, -1, -1, 0, "t3_dout_m1");
    idle(5);
    check("t3_flag0", int'(sat_flag), 0);
    check("t3_satcnt0", int'(sat_count), 0);

    // gain load mid-pulse: applied in the cycle strb_out is first low
    pulse(10, 0, 0, 100, 6, -13, 3, 5, "t4_dout_old");
    check("t4_gain_f0", int'(gain_active), -1);
    @(posedge clk) #1;
    check("t4_gain_f1", int'(gain_active), -1);
    @(posedge clk) #1;
    check("t4_strb_low", int'(strb_out), 0);
    check("t4_gain_f2", int'(gain_active), -1);
    @(posedge clk) #1;
    check("t4_gain_f3", int'(gain_active), 5);
    idle(2);
    pulse(8, 0, 0, 100, 5, 62, -1, 0, "t4_dout_new");
    idle(4);

    // load on the apply cycle: first value, then the newer one
    @(posedge clk) #1;
    gain_new = 7'sd9; gain_load = 1'b1;
    @(posedge clk) #1;
    gain_new = 7'sd11;
    @(posedge clk) #1;
    gain_load = 1'b0;
    check("t4b_gain_first", int'(gain_active), 9);
    @(posedge clk) #1;
    check("t4b_gain_second", int'(gain_active), 11);

    // reset mid-pulse with sat_flag set
    offset = -13'sd4096;
    load_gain(63);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk) #1;
      store_strb = 1'b1;
      din = 13'sd4095;
    end
    check("t5_flag_pre", int'(sat_flag), 1);
    rst = 1'b1;
    #1;
    store_strb = 1'b0;
    check("t5_dout", int'(dout), 0);
    check("t5_strb", int'(strb_out), 0);
    check("t5_gain", int'(gain_active), 0);
    check("t5_flag", int'(sat_flag), 0);
    check("t5_satcnt", int'(sat_count), 0);
    @(negedge clk) rst = 1'b0;
    offset = 13'sd200;
    load_gain(16);
    idle(2);
    pulse(40, 0, 0, 1000, 20, 1600, -1, 0, "t5_dout_after");
    idle(5);
    check("t5_width", last_w, 40);

    // counter saturation
    offset = -13'sd4096;
    load_gain(63);
    idle(2);
    pulse(1100, 1100, 4095, 0, 500, 32767, -1, 0, "t6_dout");
    idle(5);
    check("t6_satcnt", int'(sat_count), 1023);

    // back-to-back pulses, one-cycle gap
    pulse(5, 3, 4095, 0, -1, 0, -1, 0, "t7a");
    pulse(8, 8, 4095, 0, -1, 0, -1, 0, "t7b");
    check("t7_satcnt_a", int'(sat_count), 3);
    idle(5);
    check("t7_satcnt_b", int'(sat_count), 8);

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ff_gain_stage.md
# ff_gain_stage

Feed-forward gain stage that sits directly upstream of the amplifier-drive/DAC output stage. It takes the processed position sample stream during the store-strobe window and subtracts a programmable offset. It then multiplies by a signed loop gain, scales and saturates the result to the 16-bit drive word, and forwards it with a matching delayed strobe. Gain updates are applied only between pulses, and the block reports per-pulse saturation statistics to the host.

## Interface
Parameters:
- DIN_W, 13, input sample width (signed)
- GAIN_W, 7, gain width (signed)
- DOUT_W, 16, output drive width (signed)
- GAIN_SHIFT, 3, arithmetic right shift applied to the product
- CNT_W, 10, saturation counter width

Ports:
- clk  in  1  system clock (one clock domain)
- rst  in  1  asynchronous, active-high reset
- store_strb  in  1  pulse processing window from upstream
- din  in  DIN_W  signed position sample, valid while store_strb high
- offset  in  DIN_W  signed offset subtracted from din (quasi-static)
- gain_new  in  GAIN_W  signed gain value from host register
- gain_load  in  1  single-cycle strobe capturing gain_new
- dout  out  DOUT_W  signed scaled, saturated drive word
- strb_out  out  1  store_strb delayed to align with dout
- gain_active  out  GAIN_W  gain currently applied
- sat_flag  out  1  sticky: saturation occurred in current pulse
- sat_count  out  CNT_W  saturated-sample count of last completed pulse

## Operation
- Stage 1 (registered): diff = din − offset, DIN_W+1 bits signed. When store_strb is low, diff is forced to 0.
- Stage 2 (registered): prod = diff × gain_active, DIN_W+1+GAIN_W bits; scaled = prod >>> GAIN_SHIFT (arithmetic).
  - If scaled > 2^(DOUT_W−1)−1, dout = 0x7FFF and the sample is flagged saturated.
  - If scaled < −2^(DOUT_W−1), dout = 0x8000 and the sample is flagged saturated.
  - Otherwise dout = scaled.
- Gain handling:
  - gain_load writes gain_new into gain_pending and sets pend.
  - A later load before application overwrites gain_pending.
  - Gain is applied (gain_active <= gain_pending, pend cleared) on any cycle where pend=1 and both store_strb and strb_out are low, so gain never changes mid-pulse.
- Pulse FSM, driven by strb_out:
  - IDLE: waits for strb_out=1, then goes to ACTIVE, clearing sat_flag and the internal counter.
  - ACTIVE: each saturated output sample sets sat_flag and increments the counter, which holds at 2^CNT_W−1. strb_out=0 moves to PUBLISH.
  - PUBLISH: one cycle; sat_count <= counter; go to IDLE. If strb_out has already risen again, go to ACTIVE instead.

## Timing
- Latency din→dout: 2 cycles. strb_out = store_strb delayed 2 cycles.
- dout = 0 whenever the sample entering stage 1 had store_strb low.
- gain_load at cycle n while idle: gain_active updates at n+2 (capture at n+1, apply at n+2).
- gain_load during a pulse: applied on the first cycle after the strb_out falling edge.
- Simultaneous gain_load and apply cycle: the newly loaded value wins on the following cycle.
- sat_count updates one cycle after the strb_out falling edge. sat_flag stays valid until the next strb_out rising edge.
- Reset (any time, including mid-pulse): dout=0, strb_out=0, gain_active=0, pend=0, sat_flag=0, sat_count=0, FSM=IDLE, pipeline cleared.
- Strobe gaps of one cycle are legal; they produce a PUBLISH→ACTIVE transition.

## Structure
- Shared package: DIN_W, GAIN_W, DOUT_W, CNT_W defaults, and the FSM state enum (IDLE, ACTIVE, PUBLISH).
- One sub-module, sat_scale: combinational shift-and-saturate returning the value and a saturation flag. It is reused by other gain paths.
- Strobe delay, gain latch and FSM live in the top module.

## Test plan
- offset=200, gain=16, din=1000 held for a 40-cycle strobe -> dout=1600 from 2 cycles after strobe rise; strb_out is 40 cycles wide; sat_count=0.
- din=4095, offset=−4096, gain=63 -> dout=32767, sat_flag=1. With 10 such samples in the pulse, sat_count=10 after the fall.
- din=−4096, offset=4095, gain=63 -> dout=−32768 and the sample counts as saturated. With gain=−1, din=8, offset=0 -> dout=−1, not saturated.
- gain_load gain_new=5 mid-pulse -> gain_active unchanged until the cycle after strb_out falls, then 5. Next pulse scales by 5.
- rst asserted mid-pulse with sat_flag=1 -> all outputs 0 immediately. A pulse after release behaves as from power-up.
- Pulse with 1100 saturated samples -> sat_count=1023. Back-to-back strobes with a 1-cycle gap -> two independent sat_count publications.
